// File: rtl/thold_readback_tx.sv
`default_nettype none
// ============================================================================
// Module      : thold_readback_tx
// Description : UART readback transmitter for the threshold SRAM. A start
//               pulse sends a fixed header byte and then NUM_WORDS bytes read
//               from SRAM addresses 0 upward, each framed as 8N1 on uart_tx.
//               This module contains its own baud counter and bit serializer.
//               Optional build macro THOLD_RB_CHECKSUM_EN appends one byte,
//               the XOR of all data bytes, after the last data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module thold_readback_tx #(
  parameter int          BAUD_DIV  = 434,
  parameter int          NUM_WORDS = 3,
  parameter int          AW        = 2,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  output logic          Sram_Re,
  output logic [AW-1:0] Sram_addr,
  input  logic [7:0]    Sram_rdata,
  output logic          uart_tx,
  output logic          busy,
  output logic          done
);

  // Last cycle of an ordinary bit period.
  localparam logic [15:0] c_baud_last = 16'(BAUD_DIV - 1);
  // The stop bit leaves SHIFT one cycle early: the NEXT cycle supplies the
  // final stop-bit cycle, so the two read cycles that follow form exactly
  // the two-cycle idle gap before the next start bit.
  localparam logic [15:0] c_stop_exit = 16'(BAUD_DIV - 2);
  // Index of the final data word; one extra bit so 2**AW words never wrap.
  localparam logic [AW:0] c_last_idx  = (AW+1)'(NUM_WORDS - 1);
  // Bit counter values: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  localparam logic [3:0]  c_last_data = 4'd8;
  localparam logic [3:0]  c_stop_bit  = 4'd9;

`ifdef THOLD_RB_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RD_REQ    = 3'd2,
    RD_WAIT   = 3'd3,
    SHIFT     = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6,
    CSUM_LOAD = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RD_REQ    = 3'd2,
    RD_WAIT   = 3'd3,
    SHIFT     = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6
  } state_t;
`endif

  state_t          r_state;
  logic [7:0]      r_shift;    // byte being serialized, LSB goes out next
  logic [AW:0]     r_idx;      // data word index within the frame
  logic [15:0]     r_baud;     // cycle count within the current bit
  logic [3:0]      r_bit;      // bit position within the current byte
  logic            r_is_hdr;   // byte in flight is the header
`ifdef THOLD_RB_CHECKSUM_EN
  logic [7:0]      r_csum;     // running XOR of data bytes
  logic            r_is_csum;  // byte in flight is the checksum
  logic            r_pad;      // first of the two CSUM_LOAD cycles
`endif

  // Frame sequencer, baud timing, serializer and all registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_shift   <= 8'h00;
      r_idx     <= '0;
      r_baud    <= 16'd0;
      r_bit     <= 4'd0;
      r_is_hdr  <= 1'b0;
`ifdef THOLD_RB_CHECKSUM_EN
      r_csum    <= 8'h00;
      r_is_csum <= 1'b0;
      r_pad     <= 1'b0;
`endif
      Sram_Re   <= 1'b0;
      Sram_addr <= '0;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end

        // Header goes out directly; the start bit is driven from here so it
        // appears two cycles after the accepted start.
        LOAD: begin
          r_shift   <= HEADER;
          r_idx     <= '0;
          r_is_hdr  <= 1'b1;
`ifdef THOLD_RB_CHECKSUM_EN
          r_csum    <= 8'h00;
          r_is_csum <= 1'b0;
`endif
          r_baud    <= 16'd0;
          r_bit     <= 4'd0;
          uart_tx   <= 1'b0;
          r_state   <= SHIFT;
        end

        // Strobe is already high this cycle; drop it so it lasts one cycle.
        RD_REQ: begin
          Sram_Re <= 1'b0;
          r_state <= RD_WAIT;
        end

        // Registered SRAM returns data now; capture it and begin the start bit.
        RD_WAIT: begin
          r_shift <= Sram_rdata;
`ifdef THOLD_RB_CHECKSUM_EN
          r_csum  <= r_csum ^ Sram_rdata;
`endif
          r_baud  <= 16'd0;
          r_bit   <= 4'd0;
          uart_tx <= 1'b0;
          r_state <= SHIFT;
        end

        SHIFT: begin
          if ((r_bit == c_stop_bit) && (r_baud == c_stop_exit)) begin
            r_baud  <= 16'd0;
            r_bit   <= 4'd0;
            r_state <= NEXT;
          end else if (r_baud == c_baud_last) begin
            r_baud  <= 16'd0;
            r_bit   <= r_bit + 1'b1;
            // After the last data bit the line returns high for the stop bit.
            uart_tx <= (r_bit == c_last_data) ? 1'b1 : r_shift[0];
            r_shift <= {1'b1, r_shift[7:1]};
          end else begin
            r_baud  <= r_baud + 1'b1;
          end
        end

        // Final stop-bit cycle; decide what follows the byte just sent.
        NEXT: begin
          if (r_is_hdr) begin
            r_is_hdr  <= 1'b0;
            Sram_Re   <= 1'b1;
            Sram_addr <= '0;
            r_state   <= RD_REQ;
`ifdef THOLD_RB_CHECKSUM_EN
          end else if (r_is_csum) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= DONE;
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == c_last_idx) begin
`ifdef THOLD_RB_CHECKSUM_EN
              r_pad   <= 1'b1;
              r_state <= CSUM_LOAD;
`else
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= DONE;
`endif
            end else begin
              Sram_Re   <= 1'b1;
              Sram_addr <= Sram_addr + 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end

`ifdef THOLD_RB_CHECKSUM_EN
        // Two cycles here match the RD_REQ/RD_WAIT gap of a data byte.
        CSUM_LOAD: begin
          if (r_pad) begin
            r_pad <= 1'b0;
          end else begin
            r_shift   <= r_csum;
            r_is_csum <= 1'b1;
            r_baud    <= 16'd0;
            r_bit     <= 4'd0;
            uart_tx   <= 1'b0;
            r_state   <= SHIFT;
          end
        end
`endif

        // done is high for exactly this cycle; start here is not looked at.
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thold_readback_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_thold_readback_tx
// Description : Self-checking bench for thold_readback_tx. Two instances
//               (NUM_WORDS=3 and NUM_WORDS=4 with AW=2) are driven with
//               directed and random SRAM contents. Expected line bytes and
//               read addresses are queued when a frame is launched; monitors
//               decode uart_tx, watch the SRAM strobe and the done pulse.
//               Honours THOLD_RB_CHECKSUM_EN for the expected frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thold_readback_tx;

  localparam int B      = 4;       // cycles per bit
  localparam int AWB    = 2;
  localparam int BYTE_T = 10 * B;  // cycles per 8N1 byte

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input int inst, input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL inst%0d %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               inst, name, act, act, expv, expv, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int NW     = (gi == 0) ? 3 : 4;
    localparam int BUDGET = (NW + 3) * (BYTE_T + 2) + 40;

    logic           rst_n;
    logic           start;
    logic           sram_re;
    logic [AWB-1:0] sram_addr;
    logic [7:0]     sram_rdata;
    logic           tx;
    logic           busy;
    logic           done;

    logic [7:0]     mem [4];
    logic [7:0]     exp_q [$];
    logic [AWB-1:0] addr_q [$];
    int             frames_pending = 0;
    int             start_cyc      = 0;
    bit             finished       = 1'b0;

    // line decoder state
    bit             in_byte       = 1'b0;
    int             t0            = 0;
    int             pos           = 0;
    int             last_fall     = 0;
    int             byte_in_frame = 0;
    logic           prev_tx       = 1'b1;
    logic           cur_bit       = 1'b0;
    logic [9:0]     bits          = '0;
    bit             glitch        = 1'b0;
    int             rd_addr       = 0;

    thold_readback_tx #(
      .BAUD_DIV  (B),
      .NUM_WORDS (NW),
      .AW        (AWB),
      .HEADER    (8'hA5)
    ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .start      (start),
      .Sram_Re    (sram_re),
      .Sram_addr  (sram_addr),
      .Sram_rdata (sram_rdata),
      .uart_tx    (tx),
      .busy       (busy),
      .done       (done)
    );

    // registered SRAM read port
    always @(posedge clk) if (sram_re) sram_rdata <= mem[sram_addr];

    // uart_tx decoder and done checker
    always @(negedge clk) begin
      if (!rst_n) begin
        in_byte       = 1'b0;
        byte_in_frame = 0;
        prev_tx       = 1'b1;
      end else begin
        if (in_byte) begin
          pos = cyc - t0;
          if (pos % B == 0) begin
            cur_bit        = tx;
            bits[pos / B]  = tx;
          end else if (tx !== cur_bit) begin
            glitch = 1'b1;
          end
          if (pos == BYTE_T - 1) begin
            in_byte = 1'b0;
            chk(gi, "byte_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk(gi, "byte_value", int'(bits[8:1]), int'(exp_q.pop_front()));
            chk(gi, "stop_bit", int'(bits[9]), 1);
            chk(gi, "bit_hold", int'(glitch), 0);
            byte_in_frame++;
          end
        end else if (prev_tx === 1'b1 && tx === 1'b0) begin
          in_byte = 1'b1;
          t0      = cyc;
          cur_bit = 1'b0;
          bits    = '0;
          glitch  = 1'b0;
          chk(gi, "busy_in_byte", int'(busy === 1'b1), 1);
          if (byte_in_frame == 0) chk(gi, "start_latency", cyc - start_cyc, 2);
          else                    chk(gi, "byte_spacing", cyc - last_fall, BYTE_T + 2);
          last_fall = cyc;
        end
        if (done === 1'b1) begin
          chk(gi, "done_expected", int'(frames_pending > 0), 1);
          chk(gi, "done_timing", cyc - last_fall, BYTE_T);
          chk(gi, "done_busy", int'(busy === 1'b1), 0);
          chk(gi, "bytes_left", exp_q.size(), 0);
          chk(gi, "reads_left", addr_q.size(), 0);
          if (frames_pending > 0) frames_pending--;
          byte_in_frame = 0;
        end
        prev_tx = tx;
      end
    end

    // SRAM strobe checker
    always @(negedge clk) begin
      if (rst_n && sram_re === 1'b1) begin
        chk(gi, "read_expected", int'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) begin
          rd_addr = int'(addr_q.pop_front());
          chk(gi, "sram_addr", int'(sram_addr), rd_addr);
          chk(gi, "read_order", byte_in_frame, rd_addr + 1);
        end
      end
    end

    task automatic launch();
      exp_q.push_back(8'hA5);
      for (int i = 0; i < NW; i++) begin
        exp_q.push_back(mem[i]);
        addr_q.push_back(AWB'(i));
      end
`ifdef THOLD_RB_CHECKSUM_EN
      begin : b_csum
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NW; i++) x ^= mem[i];
        exp_q.push_back(x);
      end
`endif
      frames_pending++;
      start_cyc = cyc;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk(gi, "busy_after_start", int'(busy === 1'b1), 1);
    endtask

    task automatic wait_done();
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < BUDGET);
      chk(gi, "done_seen", int'(done === 1'b1), 1);
    endtask

    task automatic pulse_ignored_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    endtask

    initial begin
      rst_n = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk(gi, "rst_tx", int'(tx), 1);
      chk(gi, "rst_busy", int'(busy), 0);
      chk(gi, "rst_done", int'(done), 0);
      chk(gi, "rst_re", int'(sram_re), 0);
      chk(gi, "rst_addr", int'(sram_addr), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed frame with a start pulse mid-frame and one in the DONE cycle
      if (gi == 0) begin
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      end else begin
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h80; mem[3] = 8'h01;
      end
      launch();
      repeat (60) @(negedge clk);
      pulse_ignored_start();
      wait_done();
      chk(gi, "addr_final", int'(sram_addr), NW - 1);
      pulse_ignored_start();
      repeat (BYTE_T) @(negedge clk);
      chk(gi, "idle_busy", int'(busy), 0);
      chk(gi, "idle_tx", int'(tx), 1);

      // random frames, each launched the cycle after the previous DONE
      for (int f = 0; f < 4; f++) begin
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        launch();
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(5, 80)) @(negedge clk);
          pulse_ignored_start();
        end
        wait_done();
        @(negedge clk);
      end

      // reset during data bit 3 of byte 0x34
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      launch();
      while (cyc < start_cyc + 2 + 2 * (BYTE_T + 2) + 4 * B + 1) @(negedge clk);
      exp_q.delete();
      addr_q.delete();
      frames_pending = 0;
      rst_n = 1'b0;
      #1;
      chk(gi, "abort_tx", int'(tx), 1);
      chk(gi, "abort_busy", int'(busy), 0);
      repeat (4) @(negedge clk);
      chk(gi, "abort_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);
      launch();
      wait_done();
      repeat (5) @(negedge clk);
      finished = 1'b1;
    end
  end

  initial begin
    for (int n = 0; n < 30000 && !(g_inst[0].finished && g_inst[1].finished); n++)
      @(posedge clk);
    if (!(g_inst[0].finished && g_inst[1].finished)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got unfinished run expected both instances finished");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
